// File: rtl/serial_parity_pkg.sv
// Shared definitions for the XOR serial parity link (transmitter and receiver).
package serial_parity_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY
  } state_t;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_checker_parity_accum.sv
// 1-bit clocked XOR accumulator: clear has priority over load, load over enable.
module parity_accum (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic r_acc;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= 1'b0;
    end else if (i_load) begin
      r_acc <= i_d;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_d;
    end
  end

  assign o_q = r_acc;

endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises LSB-first frames, checks the trailing parity bit and counts parity errors.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter bit          ODD_PARITY = PARITY_EVEN,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 in_sof,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  output logic                 parity_err,
  output logic                 frame_abort,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DATA_W-1:0]      r_shift;
  logic [CNT_W-1:0]       r_cnt;
  logic [DATA_W-1:0]      r_out_data;
  logic                   r_out_valid;
  logic                   r_parity_err;
  logic                   r_frame_abort;
  logic                   r_busy;
  logic [ERR_CNT_W-1:0]   r_err_count;

  logic w_restart;
  logic w_data_bit;
  logic w_parity_bit;
  logic w_last_bit;
  logic w_parity;
  logic w_mismatch;

  assign w_restart    = in_valid && in_sof;
  assign w_data_bit   = in_valid && !in_sof && (r_state == S_DATA);
  assign w_parity_bit = in_valid && !in_sof && (r_state == S_PARITY);
  assign w_last_bit   = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_mismatch   = in_bit != (w_parity ^ ODD_PARITY);

  parity_accum u_parity (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (1'b0),
    .i_load (w_restart),
    .i_en   (w_data_bit),
    .i_d    (in_bit),
    .o_q    (w_parity)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_restart) begin
      w_state_nxt = S_DATA;
    end else if (w_data_bit && w_last_bit) begin
      w_state_nxt = S_PARITY;
    end else if (w_parity_bit) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Bits enter at the MSB and shift right, so after DATA_W bits the first one sits at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_parity_err  <= 1'b0;
      r_frame_abort <= 1'b0;
      r_busy        <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_out_valid   <= w_parity_bit;
      r_frame_abort <= w_restart && (r_state != S_IDLE);

      if (w_restart) begin
        r_shift <= {in_bit, {(DATA_W-1){1'b0}}};
        r_cnt   <= CNT_W'(1);
      end else if (w_data_bit) begin
        r_shift <= {in_bit, r_shift[DATA_W-1:1]};
        r_cnt   <= r_cnt + 1'b1;
      end

      if (w_parity_bit) begin
        r_out_data   <= r_shift;
        r_parity_err <= w_mismatch;
        if (w_mismatch && (r_err_count != '1)) begin
          r_err_count <= r_err_count + 1'b1;
        end
      end
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign parity_err  = r_parity_err;
  assign frame_abort = r_frame_abort;
  assign busy        = r_busy;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench: an even-parity and an odd-parity checker fed the same serial stream.
module tb_serial_parity_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic in_sof = 1'b0;

  logic [7:0] e_data, o_data;
  logic       e_valid, o_valid, e_perr, o_perr, e_abort, o_abort, e_busy, o_busy;
  logic [7:0] e_cnt, o_cnt;

  int checks = 0;
  int errors = 0;
  int m_cnt_e = 0;
  int m_cnt_o = 0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1'b0), .ERR_CNT_W(8)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .out_data(e_data), .out_valid(e_valid), .parity_err(e_perr),
    .frame_abort(e_abort), .busy(e_busy), .err_count(e_cnt)
  );

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1'b1), .ERR_CNT_W(8)) dut_o (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .out_data(o_data), .out_valid(o_valid), .parity_err(o_perr),
    .frame_abort(o_abort), .busy(o_busy), .err_count(o_cnt)
  );

  typedef struct {
    logic [7:0] word;
    logic       pbit;
    bit         gaps;
    logic       err_e;
    logic       err_o;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Present one accepted bit; returns 1 time unit after the edge that sampled it.
  task automatic send_bit(input logic b, input logic sof);
    in_valid = 1'b1;
    in_bit   = b;
    in_sof   = sof;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_bit   = 1'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      in_sof   = 1'($urandom);
      in_bit   = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic p, input bit gaps,
                            input logic exp_abort, input logic err_e, input logic err_o);
    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0) idle_cycles(int'($urandom_range(0, 3)));
      send_bit(w[i], (i == 0));
      if (i == 0) chk("frame_abort_first_bit", e_abort, exp_abort);
      if (i == 1) chk("frame_abort_cleared", e_abort, 1'b0);
      chk("out_valid_low_in_data", e_valid, 1'b0);
      chk("busy_in_data", e_busy, 1'b1);
    end
    if (gaps) idle_cycles(int'($urandom_range(1, 3)));
    send_bit(p, 1'b0);
    if (err_e && m_cnt_e < 255) m_cnt_e++;
    if (err_o && m_cnt_o < 255) m_cnt_o++;
    chk("e_out_valid", e_valid, 1'b1);
    chk("e_out_data", e_data, w);
    chk("e_parity_err", e_perr, err_e);
    chk("e_err_count", e_cnt, m_cnt_e);
    chk("o_out_valid", o_valid, 1'b1);
    chk("o_out_data", o_data, w);
    chk("o_parity_err", o_perr, err_o);
    chk("o_err_count", o_cnt, m_cnt_o);
    chk("busy_after_parity", e_busy, 1'b0);
  endtask

  vec_t vecs[9];

  initial begin
    // A5: 4 ones; 01: 1; F0/0F/3C/C3: 4; 80: 1; 7F: 7; FF: 8
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data", e_data, 8'h00);
    chk("rst_out_valid", e_valid, 1'b0);
    chk("rst_parity_err", e_perr, 1'b0);
    chk("rst_frame_abort", e_abort, 1'b0);
    chk("rst_busy", e_busy, 1'b0);
    chk("rst_err_count", e_cnt, 8'h00);
    rst = 1'b0;

    // Stray non-sof bits in IDLE are discarded.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("idle_stray_busy", e_busy, 1'b0);
    chk("idle_stray_valid", e_valid, 1'b0);
    idle_cycles(2);

    // Table frames go back to back: each sof lands in the cycle after the previous parity bit.
    foreach (vecs[i])
      send_frame(vecs[i].word, vecs[i].pbit, vecs[i].gaps, 1'b0, vecs[i].err_e, vecs[i].err_o);
    idle_cycles(1);
    chk("valid_single_cycle", e_valid, 1'b0);
    chk("busy_idle_after_frames", e_busy, 1'b0);
    chk("hold_out_data", e_data, 8'hFF);

    // Abort from DATA: sof plus 4 more bits, then a restarted 3C frame.
    send_bit(1'b1, 1'b1);
    chk("no_abort_from_idle", e_abort, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Abort from PARITY: full 8 data bits, then sof instead of the parity bit.
    idle_cycles(1);
    for (int i = 0; i < 8; i++) send_bit(1'b1, (i == 0));
    chk("abort_source_valid_low", e_valid, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Saturation of the even checker's error counter.
    for (int n = 0; n < 300; n++) send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("err_count_saturated", e_cnt, 8'hFF);

    // Reset mid-frame after 4 data bits.
    idle_cycles(1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, (i == 0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cnt_e = 0;
    m_cnt_o = 0;
    chk("midrst_busy", e_busy, 1'b0);
    chk("midrst_abort", e_abort, 1'b0);
    chk("midrst_valid", e_valid, 1'b0);
    chk("midrst_err_count", e_cnt, 8'h00);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(1);
    chk("midrst_valid_low_after", e_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
